spell_mem_arbiter: RTL and testbench

Two-port arbiter that shares the single spell internal memory (512×8 SRAM, code + data halves) between the spell core and the host/debug access port. It sits between both requesters and the memory wrapper's select/write/data_ready port, serialising their transactions, and holds each transaction's address, data and type stable. It returns read data and a level completion flag to the winning requester.

---
 rtl/spell_mem_arbiter.sv | 176 +++++++++++++++++
 tb/tb_spell_mem_arbiter.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spell_mem_arbiter.sv
// Two-port arbiter sharing the spell 512x8 SRAM port between the core and the host/debug port.
// Build option SPELL_MEM_ARB_ROUND_ROBIN_EN selects round-robin tie-breaking; default is core priority.
module spell_mem_arbiter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       core_select,
  input  logic [7:0] core_addr,
  input  logic [7:0] core_data_in,
  input  logic       core_memory_type_data,
  input  logic       core_write,
  output logic [7:0] core_data_out,
  output logic       core_ready,
  input  logic       host_select,
  input  logic [7:0] host_addr,
  input  logic [7:0] host_data_in,
  input  logic       host_memory_type_data,
  input  logic       host_write,
  output logic [7:0] host_data_out,
  output logic       host_ready,
  output logic       mem_select,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_data_in,
  output logic       mem_memory_type_data,
  output logic       mem_write,
  input  logic [7:0] mem_data_out,
  input  logic       mem_data_ready,
  output logic [1:0] dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2
  } state_e;

  // Handshake: a requester raises x_select and holds it until x_ready; x_ready is a level that stays
  // high until the requester drops x_select, and the requester is not granted again until then.
  state_e     state_q, state_d;
  logic       owner_q, owner_d;
  logic       abort_q, abort_d;
  logic       mem_sel_q, mem_sel_d;
  logic [7:0] mem_addr_q, mem_addr_d;
  logic [7:0] mem_din_q, mem_din_d;
  logic       mem_type_q, mem_type_d;
  logic       mem_wr_q, mem_wr_d;
  logic       core_done_q, core_done_d;
  logic       host_done_q, host_done_d;
  logic [7:0] core_dout_q, core_dout_d;
  logic [7:0] host_dout_q, host_dout_d;

  logic core_elig;
  logic host_elig;
  logic pick_host;
  logic owner_sel;

  assign core_elig = core_select & ~core_done_q;
  assign host_elig = host_select & ~host_done_q;
  assign owner_sel = owner_q ? host_select : core_select;

`ifdef SPELL_MEM_ARB_ROUND_ROBIN_EN
  logic last_host_q, last_host_d;

  // On a tie the requester that was not granted last wins.
  assign pick_host = host_elig & (~core_elig | ~last_host_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_host_q <= 1'b1;
    end else begin
      last_host_q <= last_host_d;
    end
  end

  always_comb begin
    last_host_d = last_host_q;
    if ((state_q != BUSY) && (core_elig || host_elig)) begin
      last_host_d = pick_host;
    end
  end
`else
  assign pick_host = host_elig & ~core_elig;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      abort_q     <= 1'b0;
      mem_sel_q   <= 1'b0;
      mem_addr_q  <= 8'h00;
      mem_din_q   <= 8'h00;
      mem_type_q  <= 1'b0;
      mem_wr_q    <= 1'b0;
      core_done_q <= 1'b0;
      host_done_q <= 1'b0;
      core_dout_q <= 8'h00;
      host_dout_q <= 8'h00;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      abort_q     <= abort_d;
      mem_sel_q   <= mem_sel_d;
      mem_addr_q  <= mem_addr_d;
      mem_din_q   <= mem_din_d;
      mem_type_q  <= mem_type_d;
      mem_wr_q    <= mem_wr_d;
      core_done_q <= core_done_d;
      host_done_q <= host_done_d;
      core_dout_q <= core_dout_d;
      host_dout_q <= host_dout_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    abort_d     = abort_q;
    mem_sel_d   = mem_sel_q;
    mem_addr_d  = mem_addr_q;
    mem_din_d   = mem_din_q;
    mem_type_d  = mem_type_q;
    mem_wr_d    = mem_wr_q;
    core_done_d = core_done_q & core_select;
    host_done_d = host_done_q & host_select;
    core_dout_d = core_dout_q;
    host_dout_d = host_dout_q;

    case (state_q)
      IDLE, RELEASE: begin
        state_d = IDLE;
        if (core_elig || host_elig) begin
          state_d    = BUSY;
          owner_d    = pick_host;
          abort_d    = 1'b0;
          mem_sel_d  = 1'b1;
          mem_addr_d = pick_host ? host_addr : core_addr;
          mem_din_d  = pick_host ? host_data_in : core_data_in;
          mem_type_d = pick_host ? host_memory_type_data : core_memory_type_data;
          mem_wr_d   = pick_host ? host_write : core_write;
        end
      end
      BUSY: begin
        // Once the owner lets go, the memory cycle still runs to completion but its result is dropped.
        if (!owner_sel) begin
          abort_d = 1'b1;
        end
        if (mem_data_ready) begin
          state_d   = RELEASE;
          mem_sel_d = 1'b0;
          if (owner_sel && !abort_q) begin
            if (owner_q) begin
              host_dout_d = mem_data_out;
              host_done_d = 1'b1;
            end else begin
              core_dout_d = mem_data_out;
              core_done_d = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_select           = mem_sel_q;
  assign mem_addr             = mem_addr_q;
  assign mem_data_in          = mem_din_q;
  assign mem_memory_type_data = mem_type_q;
  assign mem_write            = mem_wr_q;
  assign core_data_out        = core_dout_q;
  assign core_ready           = core_done_q;
  assign host_data_out        = host_dout_q;
  assign host_ready           = host_done_q;
  assign dbg_state_o          = state_q;

endmodule

// File: tb/tb_spell_mem_arbiter.sv
// Bench for spell_mem_arbiter: SRAM model with post-reset fill, directed vectors, corner sequences,
// and randomized two-port traffic checked against a shadow-memory reference.
module tb_spell_mem_arbiter;

`ifdef SPELL_MEM_ARB_ROUND_ROBIN_EN
  localparam bit RR_BUILD = 1'b1;
`else
  localparam bit RR_BUILD = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       core_select, core_memory_type_data, core_write, core_ready;
  logic [7:0] core_addr, core_data_in, core_data_out;
  logic       host_select, host_memory_type_data, host_write, host_ready;
  logic [7:0] host_addr, host_data_in, host_data_out;
  logic       mem_select, mem_memory_type_data, mem_write, mem_data_ready;
  logic [7:0] mem_addr, mem_data_in, mem_data_out;
  logic [1:0] dbg_state;

  spell_mem_arbiter dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .core_select           (core_select),
    .core_addr             (core_addr),
    .core_data_in          (core_data_in),
    .core_memory_type_data (core_memory_type_data),
    .core_write            (core_write),
    .core_data_out         (core_data_out),
    .core_ready            (core_ready),
    .host_select           (host_select),
    .host_addr             (host_addr),
    .host_data_in          (host_data_in),
    .host_memory_type_data (host_memory_type_data),
    .host_write            (host_write),
    .host_data_out         (host_data_out),
    .host_ready            (host_ready),
    .mem_select            (mem_select),
    .mem_addr              (mem_addr),
    .mem_data_in           (mem_data_in),
    .mem_memory_type_data  (mem_memory_type_data),
    .mem_write             (mem_write),
    .mem_data_out          (mem_data_out),
    .mem_data_ready        (mem_data_ready),
    .dbg_state_o           (dbg_state)
  );

  // ---------------- SRAM model: 512-cycle fill to 0xFF, then zero-wait plus mem_wait extra cycles ----
  logic [7:0] sram [0:511];
  logic [9:0] init_cnt;
  int         wait_cnt;
  int         mem_wait;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_cnt       <= 10'd0;
      wait_cnt       <= 0;
      mem_data_ready <= 1'b0;
      mem_data_out   <= 8'h00;
    end else if (!init_cnt[9]) begin
      sram[init_cnt[8:0]] <= 8'hFF;
      init_cnt            <= init_cnt + 10'd1;
    end else if (mem_select) begin
      if (!mem_data_ready) begin
        if (wait_cnt < mem_wait) begin
          wait_cnt <= wait_cnt + 1;
        end else begin
          wait_cnt       <= 0;
          mem_data_ready <= 1'b1;
          if (mem_write) begin
            sram[{mem_memory_type_data, mem_addr}] <= mem_data_in;
            mem_data_out                           <= mem_data_in;
          end else begin
            mem_data_out <= sram[{mem_memory_type_data, mem_addr}];
          end
        end
      end
    end else begin
      mem_data_ready <= 1'b0;
      wait_cnt       <= 0;
    end
  end

  // ---------------- scoreboard state ----------------
  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] shadow [0:511];
  bit         m_last_host;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_port(input bit who, input bit sel, input bit wr, input bit typ,
                            input logic [7:0] addr, input logic [7:0] data);
    if (!who) begin
      core_select = sel; core_write = wr; core_memory_type_data = typ;
      core_addr = addr; core_data_in = data;
    end else begin
      host_select = sel; host_write = wr; host_memory_type_data = typ;
      host_addr = addr; host_data_in = data;
    end
  endtask

  task automatic reset_model();
    for (int i = 0; i < 512; i++) shadow[i] = 8'hFF;
    m_last_host = 1'b1;
  endtask

  task automatic do_reset();
    drive_port(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    drive_port(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    mem_wait = 0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    reset_model();
  endtask

  // One full transaction: request, wait for ready (bounded), drop select, let ready clear.
  task automatic do_txn(input bit who, input bit wr, input bit typ, input logic [7:0] addr,
                        input logic [7:0] data, output logic [7:0] got, output int cycles,
                        output int sel_cyc, output bit other_rdy, output bit timed_out);
    @(negedge clk);
    drive_port(who, 1'b1, wr, typ, addr, data);
    cycles = 0; sel_cyc = 0; other_rdy = 1'b0; timed_out = 1'b1; got = 8'h00;
    while (cycles < 2000) begin
      @(negedge clk);
      cycles++;
      if (mem_select && sel_cyc == 0) sel_cyc = cycles;
      if (who ? core_ready : host_ready) other_rdy = 1'b1;
      if (who ? host_ready : core_ready) begin
        got = who ? host_data_out : core_data_out;
        timed_out = 1'b0;
        break;
      end
    end
    drive_port(who, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    @(negedge clk);
  endtask

  typedef struct {
    bit         who;
    bit         wr;
    bit         typ;
    logic [7:0] addr;
    logic [7:0] data;
    logic [7:0] exp;
  } vec_t;

  vec_t       vecs [10];
  logic [7:0] got;
  int         cyc_n, sel_n;
  bit         oth, tmo;
  bit         winner, saw_rel, saw_rdy, drained, exp_w;

  int         st [2];
  int         gap [2];
  bit         pend [2];
  bit         prev_pend [2];
  bit         prev_sel;
  bit         r_wr [2];
  bit         r_typ [2];
  logic [7:0] r_addr [2];
  logic [7:0] r_data [2];
  bit         g_owner;
  logic [7:0] g_addr, g_din;
  bit         g_typ, g_wr;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // {who (0 core / 1 host), write, type (1 data), addr, data, expected x_data_out}
    vecs[0] = '{1'b0, 1'b0, 1'b0, 8'h10, 8'h00, 8'hFF};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 8'h03, 8'hA5, 8'hA5};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 8'h03, 8'h00, 8'hA5};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 8'h03, 8'h00, 8'hFF};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 8'h03, 8'h5A, 8'h5A};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 8'h03, 8'h00, 8'h5A};
    vecs[6] = '{1'b1, 1'b0, 1'b1, 8'h03, 8'h00, 8'hA5};
    vecs[7] = '{1'b0, 1'b1, 1'b1, 8'hFF, 8'h81, 8'h81};
    vecs[8] = '{1'b1, 1'b0, 1'b1, 8'hFF, 8'h00, 8'h81};
    vecs[9] = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'hFF};

    drive_port(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    drive_port(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    mem_wait = 0;
    reset_model();

    // Reset values
    rst_n = 1'b0;
    #12;
    check("rst_mem_select", int'(mem_select), 0);
    check("rst_mem_write", int'(mem_write), 0);
    check("rst_mem_addr", int'(mem_addr), 0);
    check("rst_mem_data_in", int'(mem_data_in), 0);
    check("rst_mem_type", int'(mem_memory_type_data), 0);
    check("rst_core_ready", int'(core_ready), 0);
    check("rst_host_ready", int'(host_ready), 0);
    check("rst_core_data_out", int'(core_data_out), 0);
    check("rst_host_data_out", int'(host_data_out), 0);
    check("rst_state", int'(dbg_state), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Request during memory fill: completes only after the 512-cycle fill
    do_txn(1'b0, 1'b0, 1'b0, 8'h10, 8'h00, got, cyc_n, sel_n, oth, tmo);
    check("init_timeout", int'(tmo), 0);
    check("init_after_fill", int'(cyc_n >= 512), 1);
    check("init_data", int'(got), 8'hFF);
    check("init_host_ready", int'(oth), 0);

    // Zero-wait latency: select after E0, ready after E2
    do_txn(1'b0, 1'b0, 1'b0, 8'h10, 8'h00, got, cyc_n, sel_n, oth, tmo);
    check("lat0_sel_cycle", sel_n, 1);
    check("lat0_ready_cycle", cyc_n, 3);
    check("lat0_data", int'(got), 8'hFF);
    check("lat0_host_ready", int'(oth), 0);

    // Two memory wait cycles stretch the sequence by two
    mem_wait = 2;
    do_txn(1'b1, 1'b0, 1'b0, 8'h10, 8'h00, got, cyc_n, sel_n, oth, tmo);
    check("lat2_ready_cycle", cyc_n, 5);
    check("lat2_data", int'(got), 8'hFF);
    mem_wait = 0;

    // Table-driven transaction vectors
    for (int i = 0; i < 10; i++) begin
      do_txn(vecs[i].who, vecs[i].wr, vecs[i].typ, vecs[i].addr, vecs[i].data, got, cyc_n, sel_n, oth, tmo);
      check($sformatf("vec%0d_timeout", i), int'(tmo), 0);
      check($sformatf("vec%0d_data", i), int'(got), int'(vecs[i].exp));
      check($sformatf("vec%0d_other_ready", i), int'(oth), 0);
    end

    // Ties: both request on the same edge, four rounds
    do_reset();
    for (int r = 0; r < 4; r++) begin
      @(negedge clk);
      drive_port(1'b0, 1'b1, 1'b0, 1'b0, 8'h10, 8'h00);
      drive_port(1'b1, 1'b1, 1'b0, 1'b0, 8'h11, 8'h00);
      tmo = 1'b1;
      for (int c = 0; c < 2000; c++) begin
        @(negedge clk);
        if (core_ready || host_ready) begin
          tmo = 1'b0;
          break;
        end
      end
      winner = host_ready;
      check($sformatf("tie%0d_timeout", r), int'(tmo), 0);
      check($sformatf("tie%0d_winner", r), int'(winner), RR_BUILD ? (r % 2) : 0);
      drive_port(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      drive_port(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      repeat (3) @(negedge clk);
      check($sformatf("tie%0d_loser_not_granted", r), int'(mem_select | core_ready | host_ready), 0);
    end

    // Abort: host drops select mid-write; the write lands but host_ready never rises
    mem_wait = 3;
    @(negedge clk);
    drive_port(1'b1, 1'b1, 1'b1, 1'b1, 8'h20, 8'h3C);
    for (int c = 0; c < 20 && !mem_select; c++) @(negedge clk);
    check("abort_granted", int'(mem_select), 1);
    @(negedge clk);
    drive_port(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    saw_rel = 1'b0; saw_rdy = 1'b0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (host_ready) saw_rdy = 1'b1;
      if (dbg_state == 2'd2) saw_rel = 1'b1;
    end
    check("abort_host_ready", int'(saw_rdy), 0);
    check("abort_via_release", int'(saw_rel), 1);
    check("abort_back_idle", int'(dbg_state), 0);
    mem_wait = 0;
    do_txn(1'b0, 1'b0, 1'b1, 8'h20, 8'h00, got, cyc_n, sel_n, oth, tmo);
    check("abort_write_landed", int'(got), 8'h3C);

    // Asynchronous reset in BUSY while the host holds a completed read
    @(negedge clk);
    drive_port(1'b1, 1'b1, 1'b0, 1'b1, 8'h20, 8'h00);
    for (int c = 0; c < 20 && !host_ready; c++) @(negedge clk);
    check("arst_host_ready_before", int'(host_ready), 1);
    check("arst_host_data_before", int'(host_data_out), 8'h3C);
    mem_wait = 6;
    drive_port(1'b0, 1'b1, 1'b0, 1'b0, 8'h10, 8'h00);
    for (int c = 0; c < 20 && !mem_select; c++) @(negedge clk);
    check("arst_busy_before", int'(mem_select), 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_mem_select", int'(mem_select), 0);
    check("arst_core_ready", int'(core_ready), 0);
    check("arst_host_ready", int'(host_ready), 0);
    check("arst_core_data", int'(core_data_out), 0);
    check("arst_host_data", int'(host_data_out), 0);
    check("arst_state", int'(dbg_state), 0);
    do_reset();

    // Randomized two-port traffic against the shadow memory
    for (int p = 0; p < 2; p++) begin
      st[p] = 0; gap[p] = $urandom_range(0, 3); pend[p] = 1'b0; prev_pend[p] = 1'b0;
    end
    prev_sel = 1'b0; drained = 1'b0;
    g_owner = 1'b0; g_addr = 8'h00; g_din = 8'h00; g_typ = 1'b0; g_wr = 1'b0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      if (mem_select && !prev_sel) begin
        if (prev_pend[0] && prev_pend[1]) exp_w = RR_BUILD ? ~m_last_host : 1'b0;
        else exp_w = prev_pend[1];
        check("rnd_grant_had_request", int'(prev_pend[0] | prev_pend[1]), 1);
        check("rnd_grant_addr", int'(mem_addr), int'(r_addr[exp_w]));
        check("rnd_grant_type", int'(mem_memory_type_data), int'(r_typ[exp_w]));
        check("rnd_grant_write", int'(mem_write), int'(r_wr[exp_w]));
        check("rnd_grant_data_in", int'(mem_data_in), int'(r_data[exp_w]));
        g_owner = exp_w; g_addr = mem_addr; g_din = mem_data_in;
        g_typ = mem_memory_type_data; g_wr = mem_write;
        m_last_host = exp_w;
      end else if (mem_select) begin
        check("rnd_stable_addr", int'(mem_addr), int'(g_addr));
        check("rnd_stable_data_in", int'(mem_data_in), int'(g_din));
        check("rnd_stable_type", int'(mem_memory_type_data), int'(g_typ));
        check("rnd_stable_write", int'(mem_write), int'(g_wr));
      end else if (!prev_sel && (prev_pend[0] || prev_pend[1])) begin
        check("rnd_lost_grant", 0, 1);
      end
      for (int p = 0; p < 2; p++) begin
        if (st[p] == 1 && (p == 1 ? host_ready : core_ready)) begin
          check("rnd_owner", int'(g_owner), p);
          check("rnd_data", int'(p == 1 ? host_data_out : core_data_out),
                int'(r_wr[p] ? r_data[p] : shadow[{r_typ[p], r_addr[p]}]));
          if (r_wr[p]) shadow[{r_typ[p], r_addr[p]}] = r_data[p];
          pend[p] = 1'b0;
          st[p] = 2;
          drive_port(p[0], 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        end else if (st[p] == 2 && !(p == 1 ? host_ready : core_ready)) begin
          st[p] = 0;
          gap[p] = $urandom_range(0, 3);
        end else if (st[p] == 0) begin
          check("rnd_spurious_ready", int'(p == 1 ? host_ready : core_ready), 0);
        end
        if (st[p] == 0) begin
          if (gap[p] > 0) begin
            gap[p]--;
          end else if (cyc < 3000) begin
            r_wr[p]   = 1'($urandom_range(0, 1));
            r_typ[p]  = 1'($urandom_range(0, 1));
            r_addr[p] = 8'h40 + 8'($urandom_range(0, 3));
            r_data[p] = 8'($urandom_range(0, 255));
            drive_port(p[0], 1'b1, r_wr[p], r_typ[p], r_addr[p], r_data[p]);
            pend[p] = 1'b1;
            st[p] = 1;
          end
        end
      end
      if (!mem_select) mem_wait = $urandom_range(0, 2);
      prev_sel = mem_select;
      prev_pend[0] = pend[0];
      prev_pend[1] = pend[1];
      if (cyc >= 3000 && st[0] == 0 && st[1] == 0) begin
        drained = 1'b1;
        break;
      end
    end
    check("rnd_drained", int'(drained), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
